spi_cfg_responder: RTL and testbench

//  Serial-interface responder for the 3-wire ADC configuration bus (SCLK/SDATA/SEN/RESET) driven by the ADC driver.

---
 rtl/spi_cfg_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_cfg_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_cfg_responder
// Description : Oversampled 3-wire configuration-bus responder with a local
//               register file, readback on spi_sdout and soft/hard reset.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_cfg_responder #(
    parameter int NUM_REGS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       RST,
    input  logic       spi_sclk,
    input  logic       spi_sdata,
    input  logic       spi_sen,
    input  logic       spi_reset,
    output logic       spi_sdout,
    output logic       spi_sdout_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       soft_rst_pulse,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        COMMIT   = 2'd2,
        WAIT_SEN = 2'd3
    } state_t;

    localparam int         PIN_W    = 4;
    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] CNT_SAT   = 5'd17;
    localparam logic [4:0] ADDR_DONE = 5'd7;

    logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q;
    logic [2:0]  prev_q;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] sr_q, sr_d;
    logic        first_q;
    logic        rd_frame_q;
    logic        oe_q, sdout_q;
    logic [7:0]  out_sr_q;
    logic [7:0]  rd_data_q;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];

    logic w_sclk, w_sdata, w_sen, w_srst;
    logic w_sclk_fall, w_sclk_rise, w_sen_fall, w_sen_rise, w_srst_rise;
    logic w_addr_ok;
    logic [7:0] w_rb_addr, w_rb_val, w_rd_val;

    assign {w_srst, w_sen, w_sdata, w_sclk} = sync_q[SYNC_STAGES-1];
    assign w_sclk_fall = prev_q[0] & ~w_sclk;
    assign w_sclk_rise = ~prev_q[0] & w_sclk;
    assign w_sen_fall  = prev_q[1] & ~w_sen;
    assign w_sen_rise  = ~prev_q[1] & w_sen;
    assign w_srst_rise = ~prev_q[2] & w_srst;
    assign w_addr_ok   = ({24'd0, sr_q[15:8]} < 32'(NUM_REGS));
    assign w_rb_addr   = {sr_q[6:0], w_sdata};

    // Synchronisers reset to 0 so a low SEN at reset release never looks like a fresh frame start.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            sync_q  <= '0;
            prev_q  <= '0;
            first_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], {spi_reset, spi_sen, spi_sdata, spi_sclk}};
            prev_q  <= {w_srst, w_sen, w_sclk};
            first_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        frame_err = 1'b0;
        wr_stb    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state_q)
            IDLE: begin
                if (w_sen_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
            end
            SHIFT: begin
                if (w_sen_rise) begin
                    if (bit_cnt_q == FRAME_LEN) begin
                        state_d = COMMIT;
                    end else begin
                        state_d   = IDLE;
                        frame_err = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    sr_d = {sr_q[14:0], w_sdata};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (!rd_frame_q && w_addr_ok) begin
                    wr_stb  = 1'b1;
                    wr_addr = sr_q[15:8];
                    wr_data = sr_q[7:0];
                end
            end
            WAIT_SEN: begin
                if (w_sen) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Hardware reset outranks any in-flight frame or pending commit.
        if (first_q || w_srst) begin
            state_d   = WAIT_SEN;
            frame_err = 1'b0;
            wr_stb    = 1'b0;
            wr_addr   = '0;
            wr_data   = '0;
        end
    end

    assign soft_rst_pulse = w_srst_rise | (wr_stb & (wr_addr == 8'h00) & wr_data[0]);

    always_comb begin
        w_rb_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rb_addr == 8'(i)) w_rb_val = regs_q[i];
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            rd_frame_q <= 1'b0;
            oe_q       <= 1'b0;
            sdout_q    <= 1'b0;
            out_sr_q   <= '0;
        end else if (state_q == SHIFT && !w_srst && !w_sen_rise) begin
            if (w_sclk_fall && bit_cnt_q == ADDR_DONE && regs_q[0][1] && w_rb_addr != 8'h00) begin
                out_sr_q   <= w_rb_val;
                oe_q       <= 1'b1;
                rd_frame_q <= 1'b1;
            end else if (w_sclk_rise && oe_q) begin
                sdout_q  <= out_sr_q[7];
                out_sr_q <= {out_sr_q[6:0], 1'b0};
            end
        end else begin
            oe_q    <= 1'b0;
            sdout_q <= 1'b0;
            if (state_q == IDLE) rd_frame_q <= 1'b0;
        end
    end

    assign spi_sdout    = sdout_q;
    assign spi_sdout_oe = oe_q;

    // Bit 0 of register 0 is never stored: it only triggers the soft reset.
    always_comb begin
        regs_d = regs_q;
        if (w_srst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
        end else if (wr_stb) begin
            if (wr_addr == 8'h00) begin
                if (wr_data[0]) begin
                    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                end else begin
                    regs_d[0] = {wr_data[7:1], 1'b0};
                end
            end else begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (wr_addr == 8'(i)) regs_d[i] = wr_data;
                end
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 8'(i)) w_rd_val = regs_d[i];
        end
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= w_rd_val;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_cfg_responder
// Description : Self-checking bench for spi_cfg_responder (vector table plus
//               multi-cycle reset/readback sequences, write scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_spi_cfg_responder;

    localparam int NUM_REGS = 32;
    localparam int SS       = 2;
    localparam int HALF     = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, sdata = 1'b0, sen = 1'b1, sreset = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic       sdout, oe, wr_stb, soft_rst, frame_err;
    logic [7:0] wr_addr, wr_data, rd_data;

    spi_cfg_responder #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SS)) dut (
        .clk_in(clk), .RST(rst), .spi_sclk(sclk), .spi_sdata(sdata),
        .spi_sen(sen), .spi_reset(sreset), .spi_sdout(sdout),
        .spi_sdout_oe(oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .soft_rst_pulse(soft_rst), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [7:0] d; int lat; } wr_t;
    wr_t exp_q[$];
    wr_t obs_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, sen_rise_cyc = 0;
    int stb_cnt = 0, err_cnt = 0, soft_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb) begin
                stb_cnt = stb_cnt + 1;
                obs_q.push_back('{a: wr_addr, d: wr_data, lat: cyc - sen_rise_cyc});
            end
            if (frame_err) err_cnt = err_cnt + 1;
            if (soft_rst)  soft_cnt = soft_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{a: a, d: d, lat: 0});
    endtask

    task automatic sb_drain();
        wr_t o, e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_stb", {o.a, o.d}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", o.a, e.a);
                chk("wr_data", o.d, e.d);
                checks++;
                if (o.lat < SS + 1 || o.lat > SS + 2) begin
                    failures++;
                    $display("FAIL wr_latency actual=%0d expected=%0d..%0d", o.lat, SS + 1, SS + 2);
                end
            end
        end
        chk("missing_wr_stb", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic sen_low();
        sen = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic sen_high();
        sen = 1'b1;
        sen_rise_cyc = cyc;
        wait_cyc(12);
    endtask

    // Data is launched with SCLK rising and sampled late in the high phase.
    task automatic send_bit(input logic b, output logic so, output logic oe_s);
        sclk  = 1'b1;
        sdata = b;
        wait_cyc(HALF - 1);
        so   = sdout;
        oe_s = oe;
        wait_cyc(1);
        sclk = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame(input logic [15:0] w, input int nbits,
                         output logic [7:0] rbits, output int oe_data, output int oe_addr);
        logic b, so, oe_s;
        rbits = '0; oe_data = 0; oe_addr = 0;
        sen_low();
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? w[15 - i] : 1'b0;
            send_bit(b, so, oe_s);
            if (i < 8) oe_addr += int'(oe_s);
            else if (i < 16) begin
                oe_data += int'(oe_s);
                rbits[15 - i] = so;
            end
        end
        sen_high();
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        wait_cyc(2);
        chk(name, rd_data, exp);
    endtask

    typedef struct {
        logic [7:0] a; logic [7:0] d; int nbits;
        bit stb; int err; logic [7:0] ra; logic [7:0] rexp;
    } vec_t;

    initial begin
        vec_t       tbl [9];
        logic [7:0] rb;
        logic       so, oe_s;
        int         od, oa, e0, s0, f0;

        tbl[0] = '{8'h05, 8'hA3, 16, 1'b1, 0, 8'h05, 8'hA3};
        tbl[1] = '{8'h05, 8'h11, 15, 1'b0, 1, 8'h05, 8'hA3};
        tbl[2] = '{8'h05, 8'h22, 17, 1'b0, 1, 8'h05, 8'hA3};
        tbl[3] = '{8'h40, 8'h77, 16, 1'b0, 0, 8'h40, 8'h00};
        tbl[4] = '{8'h1F, 8'h5A, 16, 1'b1, 0, 8'h1F, 8'h5A};
        tbl[5] = '{8'h00, 8'hFC, 16, 1'b1, 0, 8'h00, 8'hFC};
        tbl[6] = '{8'h00, 8'h00, 16, 1'b1, 0, 8'h00, 8'h00};
        tbl[7] = '{8'h00, 8'h00, 0,  1'b0, 1, 8'h1F, 8'h5A};
        tbl[8] = '{8'h0A, 8'hFF, 16, 1'b1, 0, 8'h0A, 8'hFF};

        wait_cyc(3);
        chk("reset_outputs", {sdout, oe, wr_stb, soft_rst, frame_err}, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_wr_bus", {wr_addr, wr_data}, 0);
        rst = 1'b0;
        wait_cyc(10);
        rd_chk("reset_reg05", 8'h05, 8'h00);

        foreach (tbl[k]) begin
            e0 = err_cnt; s0 = stb_cnt;
            if (tbl[k].stb) push_wr(tbl[k].a, tbl[k].d);
            frame({tbl[k].a, tbl[k].d}, tbl[k].nbits, rb, od, oa);
            sb_drain();
            chk($sformatf("vec%0d_frame_err", k), err_cnt - e0, tbl[k].err);
            chk($sformatf("vec%0d_wr_stb", k), stb_cnt - s0, int'(tbl[k].stb));
            rd_chk($sformatf("vec%0d_rd", k), tbl[k].ra, tbl[k].rexp);
        end

        // Readback mode
        push_wr(8'h00, 8'h02);
        frame(16'h0002, 16, rb, od, oa);
        sb_drain();
        rd_chk("readout_reg0", 8'h00, 8'h02);
        s0 = stb_cnt;
        frame(16'h0500, 16, rb, od, oa);
        sb_drain();
        chk("read05_bits", rb, 8'hA3);
        chk("read05_oe_data", od, 8);
        chk("read05_oe_addr", oa, 0);
        chk("read05_no_stb", stb_cnt - s0, 0);
        chk("idle_oe_sdout", {oe, sdout}, 0);
        rd_chk("read05_unchanged", 8'h05, 8'hA3);
        frame(16'h1F00, 16, rb, od, oa);
        sb_drain();
        chk("read1F_bits", rb, 8'h5A);
        frame(16'h4000, 16, rb, od, oa);
        sb_drain();
        chk("read40_bits", rb, 8'h00);
        chk("read40_oe_data", od, 8);
        push_wr(8'h00, 8'h00);
        frame(16'h0000, 16, rb, od, oa);
        sb_drain();
        rd_chk("readout_cleared", 8'h00, 8'h00);

        // Soft reset; other written bits (READOUT) are discarded
        f0 = soft_cnt;
        push_wr(8'h00, 8'h03);
        frame(16'h0003, 16, rb, od, oa);
        sb_drain();
        chk("soft_pulse", soft_cnt - f0, 1);
        rd_chk("soft_reg0", 8'h00, 8'h00);
        rd_chk("soft_reg05", 8'h05, 8'h00);
        rd_chk("soft_reg1F", 8'h1F, 8'h00);
        rd_chk("soft_reg0A", 8'h0A, 8'h00);
        push_wr(8'h1F, 8'h55);
        frame(16'h1F55, 16, rb, od, oa);
        sb_drain();
        rd_chk("post_soft_1F", 8'h1F, 8'h55);

        // RST asserted after bit 9 with SEN held low
        push_wr(8'h05, 8'h99);
        frame(16'h0599, 16, rb, od, oa);
        sb_drain();
        e0 = err_cnt;
        sen_low();
        for (int i = 0; i < 9; i++) send_bit(i == 5, so, oe_s);
        rst = 1'b1;
        wait_cyc(2);
        chk("rst_mid_outputs", {sdout, oe, wr_stb, soft_rst, frame_err}, 0);
        chk("rst_mid_rd_data", rd_data, 0);
        rst = 1'b0;
        for (int i = 9; i < 16; i++) send_bit(1'b1, so, oe_s);
        sen_high();
        sb_drain();
        chk("rst_mid_no_err", err_cnt - e0, 0);
        rd_chk("rst_mid_reg05", 8'h05, 8'h00);
        push_wr(8'h05, 8'h66);
        frame(16'h0566, 16, rb, od, oa);
        sb_drain();
        rd_chk("post_rst_reg05", 8'h05, 8'h66);

        // spi_reset pulsed mid-frame
        e0 = err_cnt; f0 = soft_cnt;
        sen_low();
        for (int i = 0; i < 5; i++) send_bit(1'b0, so, oe_s);
        sreset = 1'b1;
        wait_cyc(6);
        rd_chk("sreset_held_reg05", 8'h05, 8'h00);
        sreset = 1'b0;
        wait_cyc(4);
        for (int i = 5; i < 16; i++) send_bit(1'b1, so, oe_s);
        sen_high();
        sb_drain();
        chk("sreset_soft_pulse", soft_cnt - f0, 1);
        chk("sreset_no_err", err_cnt - e0, 0);
        rd_chk("sreset_reg1F", 8'h1F, 8'h00);
        push_wr(8'h05, 8'h12);
        frame(16'h0512, 16, rb, od, oa);
        sb_drain();
        rd_chk("post_sreset_reg05", 8'h05, 8'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
